sel_debounce: RTL and testbench

Generates the `sel` control for the `fn_sw` 2:1 selector from a raw, bouncing push-button. It synchronises and debounces the button, and each accepted press toggles `sel`. It also offers an auto-toggle mode that flips `sel` at a fixed period, which exercises the downstream mux without manual input. It sits directly upstream of `fn_sw`: `sel` connects to `fn_sw.sel`.

---
 rtl/sel_debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/sel_debounce.sv | 127 ++++++++++++
 tb/tb_sel_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sel_debounce_pkg.sv
// Shared definitions for the sel_debounce block: debounce state encodings,
// default timing parameters and a counter-width helper.
package sel_debounce_pkg;

  localparam int unsigned DB_CYCLES_DEF   = 20;
  localparam int unsigned AUTO_PERIOD_DEF = 100;

  // Debounce FSM state encodings.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  // Width of a counter that holds the values 0 .. n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sel_debounce.sv
// Debounced push-button toggle for the fn_sw select line, with an optional
// periodic auto-toggle mode.
module sel_debounce
  import sel_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned AUTO_PERIOD = AUTO_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic auto_en,
  output logic sel,
  output logic sel_pulse,
  output logic btn_level
);

  localparam int unsigned DB_W   = cnt_w(DB_CYCLES);
  localparam int unsigned AUTO_W = cnt_w(AUTO_PERIOD);

  logic              btn_s;
  db_state_e         state;
  db_state_e         state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic              btn_level_nxt;
  logic              press_acc_c;
  logic [AUTO_W-1:0] auto_cnt;
  logic [AUTO_W-1:0] auto_cnt_nxt;
  logic              auto_tc_c;
  logic              toggle_c;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      btn_level <= btn_level_nxt;
    end
  end

  // Debounce next state: db_cnt counts consecutive samples differing from the stable level.
  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    btn_level_nxt = btn_level;
    press_acc_c   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt  = WAIT_HI;
          db_cnt_nxt = DB_W'(1);
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          state_nxt     = HIGH;
          db_cnt_nxt    = '0;
          btn_level_nxt = 1'b1;
          press_acc_c   = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_nxt  = WAIT_LO;
          db_cnt_nxt = DB_W'(1);
        end
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_nxt  = HIGH;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          state_nxt     = IDLE;
          db_cnt_nxt    = '0;
          btn_level_nxt = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // Auto period counter; a manual press restarts the period.
  always_comb begin
    auto_tc_c    = auto_en && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
    auto_cnt_nxt = auto_cnt + AUTO_W'(1);
    if (!auto_en || press_acc_c || auto_tc_c) begin
      auto_cnt_nxt = '0;
    end
    toggle_c = press_acc_c || auto_tc_c;
  end

  // Select and pulse registers; coincident requests merge into one toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt  <= '0;
      sel       <= 1'b0;
      sel_pulse <= 1'b0;
    end else begin
      auto_cnt  <= auto_cnt_nxt;
      sel       <= sel ^ toggle_c;
      sel_pulse <= toggle_c;
    end
  end

endmodule

// File: tb/tb_sel_debounce.sv
// Directed self-checking bench for sel_debounce with DB_CYCLES=4, AUTO_PERIOD=10.
module tb_sel_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic auto_en;
  logic sel;
  logic sel_pulse;
  logic btn_level;

  int n_cmp = 0;
  int n_mis = 0;

  sel_debounce #(
    .DB_CYCLES   (4),
    .AUTO_PERIOD (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .auto_en   (auto_en),
    .sel       (sel),
    .sel_pulse (sel_pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs set afterwards are sampled by the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sel_pulse) pulses++;
    end
  endtask

  initial begin
    int p;
    int p2;
    int np;
    int pos[3];
    logic [4:0] bounce;

    rst_n   = 1'b0;
    btn_raw = 1'b1;
    auto_en = 1'b0;
    pos     = '{0, 0, 0};

    // Reset with the button held
    repeat (3) step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_pulse", 32'(sel_pulse), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_auto_cnt", 32'(dut.auto_cnt), 0);
    rst_n = 1'b1;
    run(5, p);
    chk("rst_pre_sel", 32'(sel), 0);
    chk("rst_pre_pulses", 32'(p), 0);
    step();
    chk("rst_acc_sel", 32'(sel), 1);
    chk("rst_acc_pulse", 32'(sel_pulse), 1);
    chk("rst_acc_level", 32'(btn_level), 1);
    step();
    chk("rst_pulse_end", 32'(sel_pulse), 0);
    btn_raw = 1'b0;
    run(5, p);
    chk("rel_pre_level", 32'(btn_level), 1);
    step();
    chk("rel_level", 32'(btn_level), 0);
    chk("rel_sel", 32'(sel), 1);
    chk("rel_pulses", 32'(p), 0);
    run(4, p);

    // Clean press, held 20 cycles
    btn_raw = 1'b1;
    run(5, p);
    chk("clean_pre_sel", 32'(sel), 1);
    step();
    chk("clean_sel", 32'(sel), 0);
    chk("clean_pulse", 32'(sel_pulse), 1);
    step();
    chk("clean_pulse_end", 32'(sel_pulse), 0);
    run(13, p);
    chk("clean_hold_pulses", 32'(p), 0);
    btn_raw = 1'b0;
    run(5, p);
    chk("clean_rel_pre", 32'(btn_level), 1);
    step();
    chk("clean_rel_level", 32'(btn_level), 0);
    chk("clean_rel_sel", 32'(sel), 0);
    run(4, p);

    // Three-cycle glitch
    btn_raw = 1'b1;
    run(3, p);
    btn_raw = 1'b0;
    run(10, p2);
    chk("glitch_pulses", 32'(p + p2), 0);
    chk("glitch_level", 32'(btn_level), 0);
    chk("glitch_sel", 32'(sel), 0);

    // Bounce 1,0,1,1,0 then stable 1
    bounce = 5'b10110;
    np = 0;
    for (int i = 4; i >= 0; i--) begin
      btn_raw = bounce[i];
      step();
      if (sel_pulse) np++;
    end
    btn_raw = 1'b1;
    run(5, p);
    chk("bounce_pre_pulses", 32'(np + p), 0);
    chk("bounce_pre_sel", 32'(sel), 0);
    step();
    chk("bounce_sel", 32'(sel), 1);
    chk("bounce_pulse", 32'(sel_pulse), 1);
    run(4, p);
    chk("bounce_post_pulses", 32'(p), 0);
    btn_raw = 1'b0;
    run(10, p);
    chk("bounce_rel_level", 32'(btn_level), 0);
    chk("bounce_rel_sel", 32'(sel), 1);

    // Auto toggle for 35 cycles
    auto_en = 1'b1;
    np = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (sel_pulse) begin
        if (np < 3) pos[np] = k;
        np++;
      end
    end
    chk("auto_count", 32'(np), 3);
    chk("auto_t1", 32'(pos[0]), 10);
    chk("auto_t2", 32'(pos[1]), 20);
    chk("auto_t3", 32'(pos[2]), 30);
    chk("auto_sel", 32'(sel), 0);
    auto_en = 1'b0;
    run(15, p);
    chk("auto_off_pulses", 32'(p), 0);
    chk("auto_off_cnt", 32'(dut.auto_cnt), 0);
    chk("auto_off_sel", 32'(sel), 0);

    // Press acceptance coinciding with the auto terminal count
    auto_en = 1'b1;
    run(4, p);
    btn_raw = 1'b1;
    run(5, p2);
    chk("coll_pre_pulses", 32'(p + p2), 0);
    step();
    chk("coll_sel", 32'(sel), 1);
    chk("coll_pulse", 32'(sel_pulse), 1);
    chk("coll_auto_cnt", 32'(dut.auto_cnt), 0);
    run(9, p);
    chk("coll_gap_pulses", 32'(p), 0);
    step();
    chk("coll_next_pulse", 32'(sel_pulse), 1);
    chk("coll_next_sel", 32'(sel), 0);

    // Mid-period press restarts the auto period
    auto_en = 1'b0;
    btn_raw = 1'b0;
    run(10, p);
    auto_en = 1'b1;
    run(2, p);
    btn_raw = 1'b1;
    run(5, p2);
    chk("mid_pre_pulses", 32'(p + p2), 0);
    step();
    chk("mid_sel", 32'(sel), 1);
    chk("mid_pulse", 32'(sel_pulse), 1);
    chk("mid_auto_cnt", 32'(dut.auto_cnt), 0);
    run(9, p);
    chk("mid_gap_pulses", 32'(p), 0);
    step();
    chk("mid_next_pulse", 32'(sel_pulse), 1);
    chk("mid_next_sel", 32'(sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
